// File: rtl/i2s_to_pwm_arghunter_pkg.sv
// Shared constants and helpers for the I2S-to-PWM tile: word sizes, pin indices
// and the sample-to-duty conversion.
package i2s_pwm_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int PWM_BITS    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_BITS    = $clog2(SAMPLE_BITS + 1);

    localparam logic [PWM_BITS-1:0] MIDSCALE = 8'h80;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(SAMPLE_BITS);

    localparam int UI_SCK         = 0;
    localparam int UI_WS          = 1;
    localparam int UI_SD          = 2;
    localparam int UO_PWM_L       = 0;
    localparam int UO_PWM_R       = 1;
    localparam int UO_FRAME_VALID = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // Signed two's-complement sample to offset-binary duty.
    function automatic logic [PWM_BITS-1:0] to_duty(input logic [SAMPLE_BITS-1:0] sample);
        return sample[SAMPLE_BITS-1 -: PWM_BITS] ^ MIDSCALE;
    endfunction

    // Short words are left-aligned so their missing LSBs read as zero.
    function automatic logic [SAMPLE_BITS-1:0] left_align(input logic [SAMPLE_BITS-1:0] shift,
                                                         input logic [CNT_BITS-1:0]    cnt);
        logic [CNT_BITS-1:0] pad;
        pad = CNT_FULL - cnt;
        return shift << pad;
    endfunction

endpackage

// File: rtl/i2s_to_pwm_arghunter_chan.sv
// One PWM channel: duty register reloaded only at the period boundary and a
// registered compare against the shared counter.
module i2s_pwm_chan
    import i2s_pwm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_period_start,
    input  logic [PWM_BITS-1:0]    i_cnt,
    input  logic [SAMPLE_BITS-1:0] i_sample,
    output logic                   o_pwm
);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [PWM_BITS-1:0] w_duty_eff;

    assign w_duty_next = to_duty(i_sample);
    // The first compare of a period already uses the duty being loaded, so a
    // period never mixes old and new duty.
    assign w_duty_eff  = i_period_start ? w_duty_next : r_duty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_duty <= MIDSCALE;
            r_pwm  <= 1'b0;
        end else begin
            if (i_period_start) begin
                r_duty <= w_duty_next;
            end
            r_pwm <= (i_cnt < w_duty_eff);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/i2s_to_pwm_arghunter.sv
// Slave I2S receiver (Philips framing, oversampled on clk) driving two 8-bit
// PWM audio outputs from the top byte of each 16-bit channel word.
module i2s_to_pwm_arghunter
    import i2s_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [SYNC_STAGES:0]     r_sck_pipe;
    logic [SYNC_STAGES-1:0]   r_ws_pipe;
    logic [SYNC_STAGES-1:0]   r_sd_pipe;
    chan_e                    r_ws_last;
    logic                     r_armed;
    logic [CNT_BITS-1:0]      r_bit_cnt;
    logic [SAMPLE_BITS-1:0]   r_shift;
    logic [SAMPLE_BITS-1:0]   r_sample_l;
    logic [SAMPLE_BITS-1:0]   r_sample_r;
    logic                     r_frame_valid;
    logic [PWM_BITS-1:0]      r_pwm_cnt;

    logic                     w_sck_rise;
    logic                     w_ws;
    logic                     w_sd;
    logic                     w_ws_change;
    logic                     w_commit;
    logic                     w_capture;
    logic [SAMPLE_BITS-1:0]   w_aligned;
    logic                     w_period_start;
    logic                     w_pwm_l;
    logic                     w_pwm_r;
    logic                     w_unused;

    assign w_unused = ^{ena, ui_in[7:3], uio_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_pipe <= '0;
            r_ws_pipe  <= '0;
            r_sd_pipe  <= '0;
        end else begin
            r_sck_pipe <= {r_sck_pipe[SYNC_STAGES-1:0], ui_in[UI_SCK]};
            r_ws_pipe  <= {r_ws_pipe[SYNC_STAGES-2:0],  ui_in[UI_WS]};
            r_sd_pipe  <= {r_sd_pipe[SYNC_STAGES-2:0],  ui_in[UI_SD]};
        end
    end

    assign w_sck_rise  = r_sck_pipe[SYNC_STAGES-1] & ~r_sck_pipe[SYNC_STAGES];
    assign w_ws        = r_ws_pipe[SYNC_STAGES-1];
    assign w_sd        = r_sd_pipe[SYNC_STAGES-1];
    assign w_ws_change = w_sck_rise & (w_ws != r_ws_last);
    // Nothing is captured or committed until a WS edge has been seen since
    // reset, so a word cut by reset never reaches a sample register.
    assign w_commit    = w_ws_change & r_armed;
    assign w_capture   = w_sck_rise & ~w_ws_change & r_armed & (r_bit_cnt < CNT_FULL);
    assign w_aligned   = left_align(r_shift, r_bit_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ws_last     <= CH_LEFT;
            r_armed       <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_sample_l    <= '0;
            r_sample_r    <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_commit & (r_ws_last == CH_RIGHT);
            if (w_ws_change) begin
                r_ws_last <= chan_e'(w_ws);
                r_armed   <= 1'b1;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                if (w_commit) begin
                    if (r_ws_last == CH_LEFT) begin
                        r_sample_l <= w_aligned;
                    end else begin
                        r_sample_r <= w_aligned;
                    end
                end
            end else if (w_capture) begin
                r_shift   <= {r_shift[SAMPLE_BITS-2:0], w_sd};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_period_start = (r_pwm_cnt == '0);

    i2s_pwm_chan u_chan_l (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_period_start (w_period_start),
        .i_cnt          (r_pwm_cnt),
        .i_sample       (r_sample_l),
        .o_pwm          (w_pwm_l)
    );

    i2s_pwm_chan u_chan_r (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_period_start (w_period_start),
        .i_cnt          (r_pwm_cnt),
        .i_sample       (r_sample_r),
        .o_pwm          (w_pwm_r)
    );

    always_comb begin
        uo_out                 = '0;
        uo_out[UO_PWM_L]       = w_pwm_l;
        uo_out[UO_PWM_R]       = w_pwm_r;
        uo_out[UO_FRAME_VALID] = r_frame_valid;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_i2s_to_pwm_arghunter.sv
// Bench for i2s_to_pwm_arghunter: drives I2S frames and checks per-period PWM
// high counts and frame_valid pulses against values derived from the samples.
module tb_i2s_to_pwm_arghunter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sck = 1'b0;
    logic       ws = 1'b0;
    logic       sd = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b00000, sd, ws, sck};

    i2s_to_pwm_arghunter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model of the free-running PWM period position, reset with the DUT.
    logic [7:0] tcnt = 8'd0;
    always @(posedge clk) tcnt <= rst_n ? tcnt + 8'd1 : 8'd0;

    int   acc_l = 0;
    int   acc_r = 0;
    int   per_l[$];
    int   per_r[$];
    int   fv_high = 0;
    int   fv_rise = 0;
    logic fv_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_l   = 0;
            acc_r   = 0;
            fv_prev = 1'b0;
        end else begin
            acc_l += int'(uo_out[0]);
            acc_r += int'(uo_out[1]);
            if (uo_out[2]) fv_high++;
            if (uo_out[2] && !fv_prev) fv_rise++;
            fv_prev = uo_out[2];
            if (tcnt == 8'd0) begin
                per_l.push_back(acc_l);
                per_r.push_back(acc_r);
                acc_l = 0;
                acc_r = 0;
            end
        end
    end

    function automatic int exp_duty(input logic [31:0] w, input int n);
        logic [15:0] s;
        if (n >= 16) s = 16'(w >> (n - 16));
        else         s = 16'(w << (16 - n));
        return int'(s[15:8] ^ 8'h80);
    endfunction

    task automatic sck_cycle(input logic w, input logic d, input int half);
        @(negedge clk);
        ws  = w;
        sd  = d;
        sck = 1'b0;
        repeat (half) @(negedge clk);
        sck = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_word(input logic w, input logic [31:0] word, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) sck_cycle(w, word[i], half);
    endtask

    task automatic ws_edge(input logic w, input int half);
        sck_cycle(w, 1'($urandom_range(0, 1)), half);
    endtask

    task automatic preamble(input int half);
        sck_cycle(1'b1, 1'b0, half);
        sck_cycle(1'b0, 1'b0, half);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int half);
        send_word(1'b0, l, n, half);
        ws_edge(1'b1, half);
        send_word(1'b1, r, n, half);
        ws_edge(1'b0, half);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_until_periods(input int target);
        int g = 0;
        while (per_l.size() < target && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (per_l.size() < target) begin
            checks++;
            failures++;
            $display("FAIL period_timeout actual=%0d required=%0d", per_l.size(), target);
        end
    endtask

    task automatic wait_periods(input int k);
        wait_until_periods(per_l.size() + k);
    endtask

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          n;
        int          el;
        int          er;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fr0, fh0, idx;
        logic [31:0] rl, rr;
        int n, half;

        vecs[0] = '{32'h7FFF,   32'h8000,   16, 255, 0};
        vecs[1] = '{32'h4000,   32'hC000,   16, 192, 64};
        vecs[2] = '{32'h123456, 32'hABCDEF, 24, 146, 43};
        vecs[3] = '{32'h00A5,   32'h005A,    8, 37,  218};
        vecs[4] = '{32'h0000,   32'hFFFF,   16, 128, 127};

        // Reset and midscale idle.
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_uo_out", int'(uo_out), 0);
        check("rst_uio_out", int'(uio_out), 0);
        check("rst_uio_oe", int'(uio_oe), 0);
        rst_n = 1'b1;
        wait_periods(2);
        check("idle_pwm_l", per_l[$], 128);
        check("idle_pwm_r", per_r[$], 128);

        preamble(8);

        for (int v = 0; v < 5; v++) begin
            fr0 = fv_rise;
            fh0 = fv_high;
            send_frame(vecs[v].l, vecs[v].r, vecs[v].n, 8);
            check($sformatf("vec%0d_fv_pulses", v), fv_rise - fr0, 1);
            check($sformatf("vec%0d_fv_width", v), fv_high - fh0, 1);
            wait_periods(2);
            check($sformatf("vec%0d_pwm_l", v), per_l[$], vecs[v].el);
            check($sformatf("vec%0d_pwm_r", v), per_r[$], vecs[v].er);
        end

        // Left commit landing near counter 100 must not touch the current period.
        send_frame(32'hC000, 32'h4000, 16, 8);
        wait_periods(2);
        check("mid_pre_l", per_l[$], 64);
        send_word(1'b0, 32'h7000, 16, 8);
        @(negedge clk);
        ws = 1'b1; sd = 1'b0; sck = 1'b0;
        repeat (8) @(negedge clk);
        begin
            int k = 0;
            while (tcnt != 8'd97 && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (tcnt != 8'd97) begin
                checks++;
                failures++;
                $display("FAIL align_timeout actual=%0d required=97", tcnt);
            end
        end
        idx = per_l.size();
        sck = 1'b1;
        repeat (8) @(negedge clk);
        send_word(1'b1, 32'h4000, 16, 8);
        ws_edge(1'b0, 8);
        wait_until_periods(idx + 2);
        check("mid_same_period_l", per_l[idx], 64);
        check("mid_next_period_l", per_l[idx + 1], 240);

        // Reset in the middle of a left word.
        send_word(1'b0, 32'hFFFF, 8, 8);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_uo_out", int'(uo_out), 0);
        rst_n = 1'b1;
        send_word(1'b0, 32'hFF, 8, 8);
        ws_edge(1'b1, 8);
        repeat (4) @(negedge clk);
        wait_periods(2);
        check("midrst_pwm_l", per_l[$], 128);
        check("midrst_pwm_r", per_r[$], 128);
        preamble(8);
        fr0 = fv_rise;
        send_frame(32'h7FFF, 32'h8000, 16, 8);
        check("midrst_fv", fv_rise - fr0, 1);
        wait_periods(2);
        check("midrst_next_l", per_l[$], 255);
        check("midrst_next_r", per_r[$], 0);

        // Random words, word lengths and SCK rates.
        for (int t = 0; t < 8; t++) begin
            rl   = $urandom;
            rr   = $urandom;
            n    = 8 + 4 * $urandom_range(0, 6);
            half = $urandom_range(4, 9);
            fr0  = fv_rise;
            send_frame(rl, rr, n, half);
            check($sformatf("rnd%0d_fv", t), fv_rise - fr0, 1);
            wait_periods(2);
            check($sformatf("rnd%0d_pwm_l", t), per_l[$], exp_duty(rl, n));
            check($sformatf("rnd%0d_pwm_r", t), per_r[$], exp_duty(rr, n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
